// File: rtl/gate_sweep_sequencer.sv
// gate_sweep_sequencer
//
// Drives a 2-input combinational gate under test through its four input
// vectors (in the order {a,b} = 11, 10, 01, 00). It compares the gate's
// output against a truth table that is latched at start, and reports a
// pass/fail summary. One start pulse runs PASSES full sweeps. Each vector is
// held for SETTLE_CYCLES+1 cycles, and the gate output is sampled on the
// last edge of that window.
//
// Optional feature: define GATE_SWEEP_STOP_ON_FAIL_EN to end the run at the
// first mismatch. When it is undefined, every vector of every pass is applied.
//
// Parameters:
//   SETTLE_CYCLES  extra hold cycles per vector (0..15)
//   PASSES         full sweeps per start (1..255)
// Ports:
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   start        begin a run (ignored while busy)
//   truth_table  expected gate output, bit index = {a,b}
//   gate_r       output of the gate under test
//   gate_a       gate input a
//   gate_b       gate input b
//   busy         run in progress
//   done         run complete, held until restart or reset
//   pass         valid with done: 1 iff err_count == 0
//   err_count    saturating mismatch count
//   fail_mask    bit v set if vector v mismatched in any pass
module gate_sweep_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] truth_table,
  input  logic       gate_r,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [3:0] fail_mask
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [7:0] LAST_PASS   = 8'(PASSES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [3:0] tt_q, tt_next;
  logic [1:0] vec, vec_next;
  logic [7:0] pass_cnt, pass_cnt_next;
  logic [3:0] settle, settle_next;
  logic [7:0] err_next;
  logic [3:0] mask_next;
  logic       pass_next;
  logic       mismatch;
  logic       stop_now;

  // State and datapath registers. Reset has priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tt_q      <= 4'd0;
      vec       <= 2'd0;
      pass_cnt  <= 8'd0;
      settle    <= 4'd0;
      err_count <= 8'd0;
      fail_mask <= 4'd0;
      pass      <= 1'b0;
    end else begin
      state     <= state_next;
      tt_q      <= tt_next;
      vec       <= vec_next;
      pass_cnt  <= pass_cnt_next;
      settle    <= settle_next;
      err_count <= err_next;
      fail_mask <= mask_next;
      pass      <= pass_next;
    end
  end

  // Next-state logic. Each vector window ends when the settle counter is
  // zero. That last cycle samples gate_r and then advances the vector, the
  // pass counter, or the state.
  always_comb begin
    state_next    = state;
    tt_next       = tt_q;
    vec_next      = vec;
    pass_cnt_next = pass_cnt;
    settle_next   = settle;
    err_next      = err_count;
    mask_next     = fail_mask;
    pass_next     = pass;
    mismatch      = 1'b0;
    stop_now      = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          tt_next       = truth_table;
          err_next      = 8'd0;
          mask_next     = 4'd0;
          pass_next     = 1'b0;
          vec_next      = 2'd3;
          pass_cnt_next = 8'd0;
          settle_next   = SETTLE_LOAD;
          state_next    = APPLY;
        end
      end

      APPLY: begin
        if (settle != 4'd0) begin
          settle_next = settle - 4'd1;
        end else begin
          mismatch = (gate_r != tt_q[vec]);
          if (mismatch) begin
            err_next  = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
            mask_next = fail_mask | (4'b0001 << vec);
          end
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
          stop_now = mismatch;
`else
          stop_now = 1'b0;
`endif
          if (stop_now) begin
            state_next = DONE;
            pass_next  = 1'b0;
          end else if (vec != 2'd0) begin
            vec_next    = vec - 2'd1;
            settle_next = SETTLE_LOAD;
          end else if (pass_cnt != LAST_PASS) begin
            pass_cnt_next = pass_cnt + 8'd1;
            vec_next      = 2'd3;
            settle_next   = SETTLE_LOAD;
          end else begin
            state_next = DONE;
            pass_next  = (err_next == 8'd0);
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // The gate inputs are forced to 00 whenever no vector is being applied.
  assign busy   = (state == APPLY);
  assign done   = (state == DONE);
  assign gate_a = busy & vec[1];
  assign gate_b = busy & vec[0];

endmodule
